fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_queue.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch queue:
//   - default parameter constants for fetch_queue
//   - fetch FSM state encoding
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_INST_W   = 16;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_RESET_PC = 0;
  localparam int DEF_PC_INC   = 2;

  // ST_REQ  : free to issue a fetch request
  // ST_WAIT : one request outstanding, its response will be queued
  // ST_DROP : one request outstanding, its response is stale and is discarded
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding fetched instruction entries.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : empties the FIFO (overrides push and pop)
//   push        : write push_data at the tail (ignored when full unless popping)
//   push_data   : entry to write
//   pop         : remove the head entry (ignored when empty)
//   head_valid  : FIFO holds at least one entry
//   head_data   : head entry (don't-care when empty)
//   count       : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A push into a full FIFO is allowed only when the head leaves the same cycle.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // once count says it was written, so reset logic here would be pure cost.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule : fetch_fifo

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch front end: issues one request at a time to instruction
// memory, follows the branch predictor, queues responses for decode and
// supports flush/restart on redirect.
//   clk, rst_n       : clock, asynchronous active-low reset
//   imem_req_valid   : fetch request to instruction memory
//   imem_req_ready   : memory accepts the request this cycle
//   imem_req_addr    : request address (current fetch PC)
//   imem_resp_valid  : response returned (>=1 cycle after acceptance)
//   imem_resp_data   : fetched instruction
//   pred_taken       : predictor verdict for imem_req_addr
//   pred_target      : predicted target for imem_req_addr
//   redirect         : flush and restart from redirect_pc
//   redirect_pc      : restart address
//   out_valid        : queue head valid to decode
//   out_ready        : decode consumes the head
//   out_inst/out_pc/out_pred_taken : head entry fields
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter int              INST_W   = DEF_INST_W,
  parameter int              DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int              PC_INC   = DEF_PC_INC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_pred_taken
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = INST_W + ADDR_W + 1;

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] infl_pc;
  logic              infl_taken;

  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  logic               accept;
  logic               push;
  logic               pop;

  // The request is gated by rst_n so it stays low throughout reset and rises
  // in the first cycle after release.  Requests are never issued when full:
  // with at most one request outstanding, this keeps a slot free for it.
  assign imem_req_valid = rst_n && (state == ST_REQ) &&
                          (count < CNT_W'(DEPTH)) && !redirect;
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Redirect suppresses both queue ports; the FIFO is flushed instead.
  assign push = (state == ST_WAIT) && imem_resp_valid && !redirect;
  assign pop  = out_valid && out_ready && !redirect;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .push       (push),
    .push_data  ({imem_resp_data, infl_pc, infl_taken}),
    .pop        (pop),
    .head_valid (out_valid),
    .head_data  (head),
    .count      (count)
  );

  assign {out_inst, out_pc, out_pred_taken} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_REQ;
      pc         <= RESET_PC;
      infl_pc    <= '0;
      infl_taken <= 1'b0;
    end else if (redirect) begin
      pc <= redirect_pc;
      case (state)
        // A response arriving with the redirect is the stale one: it is
        // discarded now, leaving nothing outstanding.
        ST_WAIT: state <= imem_resp_valid ? ST_REQ : ST_DROP;
        ST_DROP: state <= imem_resp_valid ? ST_REQ : ST_DROP;
        default: state <= ST_REQ;
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          if (accept) begin
            infl_pc    <= pc;
            infl_taken <= pred_taken;
            pc         <= pred_taken ? pred_target : pc + ADDR_W'(PC_INC);
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: if (imem_resp_valid) state <= ST_REQ;
        ST_DROP: if (imem_resp_valid) state <= ST_REQ;
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] PC_INC   = 16'd2;

  typedef struct {
    logic [15:0] inst;
    logic [15:0] pc;
    logic        taken;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [15:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [15:0] imem_resp_data = '0;
  logic        pred_taken = 1'b0;
  logic [15:0] pred_target = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_inst;
  logic [15:0] out_pc;
  logic        out_pred_taken;

  fetch_queue #(
    .ADDR_W   (16),
    .INST_W   (16),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .PC_INC   (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .out_pred_taken  (out_pred_taken)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: fetch PC, the decode queue, and whether a request is
  // outstanding and whether its answer has been made stale by a redirect.
  entry_t      q[$];
  logic [15:0] m_pc;
  logic [15:0] m_infl_pc;
  logic        m_infl_taken;
  bit          m_outstanding;
  bit          m_stale;
  logic        exp_req_valid;

  // Memory model: one pending request, answered after a programmable delay.
  bit          mem_pending;
  logic [15:0] mem_addr;
  int          mem_timer;

  // Stimulus knobs (percentages and latency range).
  int          k_ready_pct, k_out_ready_pct, k_redirect_pct, k_taken_pct, k_spur_pct;
  int          k_min_lat, k_max_lat;
  logic [15:0] k_redirect_pc, k_pred_pc, k_pred_tgt;

  function automatic logic [15:0] inst_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hBEEF;
  endfunction

  task automatic set_defaults();
    k_ready_pct = 100; k_out_ready_pct = 100; k_redirect_pct = 0; k_taken_pct = 0;
    k_spur_pct = 0; k_min_lat = 0; k_max_lat = 0;
    k_redirect_pc = 16'h0000; k_pred_pc = 16'hFFFF; k_pred_tgt = 16'h0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    pred_taken = 1'b0; pred_target = '0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    q.delete();
    m_pc = RESET_PC; m_outstanding = 0; m_stale = 0; mem_pending = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle of inputs (called at a falling edge) and derive the
  // expected request-valid from the model.
  task automatic apply();
    logic resp;
    resp = 1'b0;
    if (mem_pending) begin
      if (mem_timer == 0) resp = 1'b1;
      else mem_timer--;
    end else if ($urandom_range(99) < k_spur_pct) begin
      resp = 1'b1;
    end
    imem_resp_valid = resp;
    imem_resp_data  = (resp && mem_pending) ? inst_of(mem_addr) : 16'($urandom);
    redirect        = ($urandom_range(99) < k_redirect_pct);
    redirect_pc     = (k_redirect_pct >= 100) ? k_redirect_pc : (16'($urandom) & 16'hFFFE);
    if (m_pc == k_pred_pc) begin
      pred_taken = 1'b1; pred_target = k_pred_tgt;
    end else begin
      pred_taken  = ($urandom_range(99) < k_taken_pct);
      pred_target = 16'($urandom) & 16'hFFFE;
    end
    imem_req_ready = ($urandom_range(99) < k_ready_pct);
    out_ready      = ($urandom_range(99) < k_out_ready_pct);
    exp_req_valid  = !m_outstanding && (q.size() < DEPTH) && !redirect;
  endtask

  // Clock the cycle and update the model from the inputs that were applied.
  task automatic advance();
    bit acc;
    @(posedge clk);
    acc = exp_req_valid && imem_req_ready;
    if (imem_resp_valid && mem_pending) mem_pending = 0;
    if (redirect) begin
      q.delete();
      m_pc = redirect_pc;
      if (m_outstanding) begin
        if (imem_resp_valid) begin m_outstanding = 0; m_stale = 0; end
        else m_stale = 1;
      end
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (m_outstanding && imem_resp_valid) begin
        if (!m_stale) q.push_back('{inst: imem_resp_data, pc: m_infl_pc, taken: m_infl_taken});
        m_outstanding = 0; m_stale = 0;
      end
      if (acc) begin
        m_outstanding = 1; m_stale = 0;
        m_infl_pc = m_pc; m_infl_taken = pred_taken;
        mem_pending = 1; mem_addr = m_pc;
        mem_timer = $urandom_range(k_max_lat, k_min_lat);
        m_pc = pred_taken ? pred_target : m_pc + PC_INC;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_defaults();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    do_reset();
    apply(); #1;
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== RESET_PC) begin n_bad++; $display("FAIL first_req_addr: got %h want %h", imem_req_addr, RESET_PC); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL first_out_valid: got %b want 0", out_valid); end
    advance();
  endtask

  task automatic test_sequential();
    logic [15:0] acc[$];
    logic [15:0] pops[$];
    logic [15:0] got;
    set_defaults(); do_reset();
    for (int c = 0; c < 10; c++) begin
      apply(); #1;
      if (imem_req_valid && imem_req_ready) acc.push_back(imem_req_addr);
      if (out_valid && out_ready) pops.push_back(out_pc);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < acc.size()) ? acc[i] : 16'hDEAD;
      n_cmp++; if (got !== 16'(2 * i)) begin n_bad++; $display("FAIL seq_req_addr[%0d]: got %h want %h", i, got, 16'(2 * i)); end
      got = (i < pops.size()) ? pops[i] : 16'hDEAD;
      n_cmp++; if (got !== 16'(2 * i)) begin n_bad++; $display("FAIL seq_out_pc[%0d]: got %h want %h", i, got, 16'(2 * i)); end
    end
  endtask

  task automatic test_backpressure();
    int n_acc;
    set_defaults(); k_out_ready_pct = 0; do_reset();
    n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      apply(); #1;
      if (imem_req_valid && imem_req_ready) n_acc++;
      advance();
    end
    n_cmp++; if (n_acc !== DEPTH) begin n_bad++; $display("FAIL full_accepts: got %0d want %0d", n_acc, DEPTH); end
    apply(); #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL full_req_valid: got %b want 0", imem_req_valid); end
    advance();
    k_out_ready_pct = 100;
    apply(); #1;
    n_cmp++; if ({out_valid, out_pc} !== {1'b1, 16'h0000}) begin n_bad++; $display("FAIL full_head: got %b/%h want 1/0000", out_valid, out_pc); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL full_req_during_pop: got %b want 0", imem_req_valid); end
    advance();
    apply(); #1;
    n_cmp++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 16'h0008}) begin n_bad++; $display("FAIL after_pop_req: got %b/%h want 1/0008", imem_req_valid, imem_req_addr); end
    advance();
  endtask

  task automatic test_predict();
    logic [15:0] acc[$];
    entry_t      pops[$];
    set_defaults(); k_pred_pc = 16'h0006; k_pred_tgt = 16'h0040; do_reset();
    for (int c = 0; c < 12; c++) begin
      apply(); #1;
      if (imem_req_valid && imem_req_ready) acc.push_back(imem_req_addr);
      if (out_valid && out_ready) pops.push_back('{inst: out_inst, pc: out_pc, taken: out_pred_taken});
      advance();
    end
    if (acc.size() < 6 || pops.size() < 5) begin
      n_cmp++; n_bad++;
      $display("FAIL pred_progress: got %0d requests/%0d pops want 6/5", acc.size(), pops.size());
    end else begin
      n_cmp++; if (acc[3] !== 16'h0006) begin n_bad++; $display("FAIL pred_branch_addr: got %h want 0006", acc[3]); end
      n_cmp++; if (acc[4] !== 16'h0040) begin n_bad++; $display("FAIL pred_target_addr: got %h want 0040", acc[4]); end
      n_cmp++; if (acc[5] !== 16'h0042) begin n_bad++; $display("FAIL pred_after_target: got %h want 0042", acc[5]); end
      n_cmp++; if ({pops[2].pc, pops[2].taken} !== {16'h0004, 1'b0}) begin n_bad++; $display("FAIL pred_entry4: got %h/%b want 0004/0", pops[2].pc, pops[2].taken); end
      n_cmp++; if ({pops[3].pc, pops[3].taken} !== {16'h0006, 1'b1}) begin n_bad++; $display("FAIL pred_entry6: got %h/%b want 0006/1", pops[3].pc, pops[3].taken); end
      n_cmp++; if ({pops[4].pc, pops[4].inst} !== {16'h0040, inst_of(16'h0040)}) begin n_bad++; $display("FAIL pred_entry40: got %h/%h want 0040/%h", pops[4].pc, pops[4].inst, inst_of(16'h0040)); end
    end
  endtask

  task automatic test_redirect_wait();
    bit done;
    set_defaults(); k_min_lat = 3; k_max_lat = 3; do_reset();
    apply(); advance();
    k_redirect_pct = 100; k_redirect_pc = 16'h0100;
    apply(); #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_req_valid: got %b want 0", imem_req_valid); end
    advance();
    k_redirect_pct = 0;
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      apply(); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_out_valid: got %b want 0 (cycle %0d)", out_valid, c); end
      if (imem_req_valid && imem_req_ready) begin
        done = 1;
        n_cmp++; if (imem_req_addr !== 16'h0100) begin n_bad++; $display("FAIL redir_req_addr: got %h want 0100", imem_req_addr); end
      end
      advance();
    end
    if (!done) begin n_cmp++; n_bad++; $display("FAIL redir_timeout: got no request want 0100"); end
  endtask

  task automatic test_redirect_collide();
    set_defaults(); k_out_ready_pct = 0; do_reset();
    repeat (5) begin apply(); advance(); end
    k_redirect_pct = 100; k_redirect_pc = 16'h0200; k_out_ready_pct = 100;
    apply(); #1;
    n_cmp++; if ({out_valid, out_pc, imem_req_valid} !== {1'b1, 16'h0000, 1'b0}) begin n_bad++; $display("FAIL coll_pre: got %b/%h/%b want 1/0000/0", out_valid, out_pc, imem_req_valid); end
    advance();
    k_redirect_pct = 0;
    apply(); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL coll_flushed: got %b want 0", out_valid); end
    n_cmp++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 16'h0200}) begin n_bad++; $display("FAIL coll_req: got %b/%h want 1/0200", imem_req_valid, imem_req_addr); end
    advance();
    apply(); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL coll_nopush: got %b want 0", out_valid); end
    advance();
    apply(); #1;
    n_cmp++; if ({out_valid, out_pc, out_inst} !== {1'b1, 16'h0200, inst_of(16'h0200)}) begin n_bad++; $display("FAIL coll_entry: got %b/%h/%h want 1/0200/%h", out_valid, out_pc, out_inst, inst_of(16'h0200)); end
    advance();
  endtask

  task automatic test_midreset();
    set_defaults(); k_out_ready_pct = 0; k_min_lat = 2; k_max_lat = 2; do_reset();
    repeat (5) begin apply(); advance(); end
    apply(); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({imem_req_valid, out_valid} !== 2'b00) begin n_bad++; $display("FAIL mid_async_clear: got %b%b want 00", imem_req_valid, out_valid); end
    do_reset();
    apply(); #1;
    n_cmp++; if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, RESET_PC, 1'b0}) begin n_bad++; $display("FAIL mid_restart: got %b/%h/%b want 1/%h/0", imem_req_valid, imem_req_addr, out_valid, RESET_PC); end
    advance();
  endtask

  task automatic test_random();
    entry_t h;
    set_defaults();
    k_ready_pct = 60; k_redirect_pct = 3; k_taken_pct = 20; k_spur_pct = 5;
    k_min_lat = 0; k_max_lat = 3;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) k_out_ready_pct = (c % 1500 == 0) ? 20 : ((c % 1000 == 0) ? 100 : 70);
      apply(); #1;
      n_cmp++; if (imem_req_valid !== exp_req_valid) begin n_bad++; $display("FAIL rnd_req_valid @%0d: got %b want %b", c, imem_req_valid, exp_req_valid); end
      if (exp_req_valid) begin
        n_cmp++; if (imem_req_addr !== m_pc) begin n_bad++; $display("FAIL rnd_req_addr @%0d: got %h want %h", c, imem_req_addr, m_pc); end
      end
      n_cmp++; if (out_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_out_valid @%0d: got %b want %b", c, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        h = q[0];
        n_cmp++;
        if ({out_inst, out_pc, out_pred_taken} !== {h.inst, h.pc, h.taken}) begin
          n_bad++;
          $display("FAIL rnd_head @%0d: got %h/%h/%b want %h/%h/%b", c, out_inst, out_pc, out_pred_taken, h.inst, h.pc, h.taken);
        end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_predict();
    test_redirect_wait();
    test_redirect_collide();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit reached want bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fetch_queue
